// File: rtl/muldiv_if.sv
// Handshake and result bus between a requester (master) and muldiv_unit (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one operand bit per cycle on magnitudes, sign fixed up at the end.
// Define MULDIV_DIV_EN to compile in the divide datapath (DIV/DIVU); otherwise divide requests are ignored.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_q, neg_d;

  logic               a_neg, b_neg, accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;

`ifdef MULDIV_DIV_EN
  logic               div_q, div_d;
  logic               rneg_q, rneg_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [WIDTH-1:0]   div_acc, div_sh, quo, rem;
`endif

  always_comb begin
    a_neg   = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg   = ~bus.op[0] & bus.b[WIDTH-1];
    abs_a   = a_neg ? -bus.a : bus.a;
    abs_b   = b_neg ? -bus.b : bus.b;
`ifdef MULDIV_DIV_EN
    accept  = bus.start & ~bus.flush;
`else
    accept  = bus.start & ~bus.flush & ~bus.op[1];
`endif

    // acc holds the running upper half; sh shifts out multiplier bits and takes in product bits
    mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mb_q} : '0);
    prod    = {mul_sum[WIDTH:1], mul_sum[0], sh_q[WIDTH-1:1]};
    if (neg_q) prod = -prod;

`ifdef MULDIV_DIV_EN
    // restoring step: acc is the partial remainder, sh shifts dividend bits out and quotient bits in
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, mb_q};
    if (div_trial[WIDTH]) begin
      div_acc = div_shift[WIDTH-1:0];
      div_sh  = {sh_q[WIDTH-2:0], 1'b0};
    end else begin
      div_acc = div_trial[WIDTH-1:0];
      div_sh  = {sh_q[WIDTH-2:0], 1'b1};
    end
    quo = neg_q  ? -div_sh  : div_sh;
    rem = rneg_q ? -div_acc : div_acc;
`endif

    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    mb_d    = mb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
`ifdef MULDIV_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
`endif

    case (state_q)
      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          count_d = count_q + CNT_W'(1);
          acc_d   = mul_sum[WIDTH:1];
          sh_d    = {mul_sum[0], sh_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
          if (div_q) begin
            acc_d = div_acc;
            sh_d  = div_sh;
          end
`endif
          if (count_q == LAST) begin
            state_d = S_DONE;
            hi_d    = prod[2*WIDTH-1:WIDTH];
            lo_d    = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
            if (div_q) begin
              hi_d = rem;
              lo_d = quo;
            end
`endif
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_RUN;
          count_d = '0;
          acc_d   = '0;
          sh_d    = abs_b;
          mb_d    = abs_a;
          neg_d   = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
          div_d   = bus.op[1];
          rneg_d  = a_neg;
          dbz_d   = 1'b0;
          if (bus.op[1]) begin
            sh_d = abs_a;
            mb_d = abs_b;
            if (bus.b == '0) begin
              state_d = S_DONE;
              hi_d    = bus.a;
              lo_d    = '1;
              dbz_d   = 1'b1;
            end
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      mb_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      mb_q    <= mb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
`ifdef MULDIV_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIV_EN
  assign bus.div_by_zero = dbz_q & (state_q == S_DONE);
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at start, compared on done.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    logic signed [63:0] sa, sb, p, q, m;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    r  = '0;
    case (op)
      2'b00: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; r.hi = up[63:32]; r.lo = up[31:0]; end
      2'b10: begin
        if (b == 0) begin r.hi = a; r.lo = '1; r.dbz = 1'b1; end
        else begin q = sa / sb; m = sa % sb; r.hi = m[31:0]; r.lo = q[31:0]; end
      end
      default: begin
        if (b == 0) begin r.hi = a; r.lo = '1; r.dbz = 1'b1; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
    endcase
    return r;
  endfunction

  // Scoreboard side: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.done) begin
      if (sb_q.size() == 0) begin
        check_eq("done_unexpected", 64'(bus.done), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("hi", bus.hi, e.hi);
        check_eq("lo", bus.lo, e.lo);
        check_eq("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen (FSM in DONE).
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc, nbusy, exp_lat;
    exp_lat   = (op[1] && b == 0) ? 1 : W + 1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    sb_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.start = 1'b0;
    cyc   = 1;
    nbusy = 0;
    while (!bus.done && cyc < 200) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", 64'(cyc), 64'(exp_lat));
    check_eq("busy_cycles", 64'(nbusy), 64'(exp_lat - 1));
    check_eq("busy_at_done", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int cyc, nd, nbusy;
    logic [W-1:0] ph, pl, ra, rb;
    logic [1:0] rop;

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;

    #1;
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_hi", bus.hi, 64'd0);
    check_eq("rst_lo", bus.lo, 64'd0);
    check_eq("rst_dbz", 64'(bus.div_by_zero), 64'd0);

    @(negedge clk);
    rst = 1'b1;
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    do_op(2'b00, 32'hFFFFFFFD, 32'd5);
`ifdef MULDIV_DIV_EN
    do_op(2'b10, 32'hFFFFFFF9, 32'd2);
    @(negedge clk);
    do_op(2'b11, 32'd10, 32'd0);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    do_op(2'b10, 32'd7, 32'hFFFFFFFE);
    do_op(2'b11, 32'hFFFFFFFF, 32'd3);
`endif
    do_op(2'b00, 32'h80000000, 32'h80000000);

    // flush mid-operation: no done, results held
    @(negedge clk);
    ph = bus.hi;
    pl = bus.lo;
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'hDEADBEEF; bus.b = 32'h0BADF00D;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check_eq("flush_busy", 64'(bus.busy), 64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check_eq("flush_no_done", 64'(nd), 64'd0);
    check_eq("flush_hi_held", bus.hi, ph);
    check_eq("flush_lo_held", bus.lo, pl);

    // flush together with start wins
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check_eq("flush_beats_start", 64'(bus.busy), 64'd0);

    // start during RUN is ignored
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'h12345678; bus.b = 32'h9ABCDEF0;
    sb_q.push_back(model(2'b01, 32'h12345678, 32'h9ABCDEF0));
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      if (cyc == 20) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check_eq("ignored_start_latency", 64'(cyc), 64'(W + 1));
    @(negedge clk);

`ifdef MULDIV_DIV_EN
    // reset in the middle of a divide
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'hFFFFFF9C; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rrun_busy", 64'(bus.busy), 64'd0);
    check_eq("rrun_done", 64'(bus.done), 64'd0);
    check_eq("rrun_hi", bus.hi, 64'd0);
    check_eq("rrun_lo", bus.lo, 64'd0);
    check_eq("rrun_dbz", 64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    do_op(2'b10, 32'hFFFFFF9C, 32'd7);
    @(negedge clk);
`else
    // divide requests are ignored when the divider is not built
    ph = bus.hi;
    pl = bus.lo;
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    nd = 0;
    nbusy = 0;
    repeat (40) begin
      if (bus.busy) nbusy++;
      if (bus.done) nd++;
      @(negedge clk);
    end
    check_eq("nodiv_busy", 64'(nbusy), 64'd0);
    check_eq("nodiv_done", 64'(nd), 64'd0);
    check_eq("nodiv_hi", bus.hi, ph);
    check_eq("nodiv_lo", bus.lo, pl);
`endif

    for (int i = 0; i < 8; i++) begin
`ifdef MULDIV_DIV_EN
      rop = 2'($urandom_range(0, 3));
`else
      rop = 2'($urandom_range(0, 1));
`endif
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      do_op(rop, ra, rb);
    end

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
